// File: rtl/alu_op_sequencer_if.sv
// Operand/mode input channel shared by A, B and M words.
// The host drives din/din_valid; the sequencer answers with din_ready.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation: collects A, B, M over a valid/ready channel,
// pulses the operand-register loads, waits EXEC_CYCLES, captures the result.
module alu_op_sequencer #(
  parameter int WIDTH       = 4,
  parameter int EXEC_CYCLES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  alu_op_sequencer_if.slave    din_if,
  output logic [WIDTH-1:0]     opnd,
  output logic                 ld_a,
  output logic                 ld_b,
  output logic                 ld_m,
  input  logic [WIDTH-1:0]     alu_res,
  input  logic                 alu_cout,
  output logic [WIDTH-1:0]     result,
  output logic                 cout,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] op_count
);

  typedef enum logic [3:0] {
    IDLE,
    WAIT_A,
    WR_A,
    WAIT_B,
    WR_B,
    WAIT_M,
    WR_M,
    EXEC,
    DONE
  } state_e;

  // EXEC_CYCLES is legal in 1..15, so the down-counter fits in 4 bits.
  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 cout_q, cout_d;
  logic [3:0]           exec_cnt_q, exec_cnt_d;
  logic [CNT_WIDTH-1:0] op_count_q, op_count_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    opnd_d     = opnd_q;
    result_d   = result_q;
    cout_d     = cout_q;
    exec_cnt_d = exec_cnt_q;
    op_count_d = op_count_q;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   if (start) state_d = WAIT_A;
        WAIT_A: if (din_if.din_valid) begin opnd_d = din_if.din; state_d = WR_A; end
        WR_A:   state_d = WAIT_B;
        WAIT_B: if (din_if.din_valid) begin opnd_d = din_if.din; state_d = WR_B; end
        WR_B:   state_d = WAIT_M;
        WAIT_M: if (din_if.din_valid) begin opnd_d = din_if.din; state_d = WR_M; end
        WR_M: begin
          exec_cnt_d = EXEC_LOAD;
          state_d    = EXEC;
        end
        EXEC: begin
          if (exec_cnt_q == 4'd0) begin
            result_d   = alu_res;
            cout_d     = alu_cout;
            op_count_d = op_count_q + CNT_WIDTH'(1);
            state_d    = DONE;
          end else begin
            exec_cnt_d = exec_cnt_q - 4'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opnd_q     <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      exec_cnt_q <= '0;
      op_count_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q    <= state_d;
      opnd_q     <= opnd_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      exec_cnt_q <= exec_cnt_d;
      op_count_q <= op_count_d;
    end
  end

  // Control outputs are pure state decodes, so no input reaches an output combinationally.
  assign din_if.din_ready = (state_q == WAIT_A) || (state_q == WAIT_B) || (state_q == WAIT_M);
  assign ld_a     = (state_q == WR_A);
  assign ld_b     = (state_q == WR_B);
  assign ld_m     = (state_q == WR_M);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign opnd     = opnd_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer: a behavioural ALU/register bank plus
// a latency/result/counter model derived from the operation rules.
module tb_alu_op_sequencer;

  localparam int W        = 4;
  localparam int EXEC     = 2;
  localparam int CNT_W    = 2;
  localparam int BASE_LAT = 7 + EXEC;

  logic             clk, rst_n, start, abort;
  logic [W-1:0]     opnd, alu_res, result;
  logic             ld_a, ld_b, ld_m, alu_cout, cout, busy, done;
  logic [CNT_W-1:0] op_count;
  logic [W-1:0]     a_reg = '0, b_reg = '0, m_reg = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;
  logic [W:0] last_exp = '0;

  typedef struct packed {
    int               done_cyc;
    int               n_done;
    int               n_la;
    int               n_lb;
    int               n_lm;
    logic             overlap;
    logic             post_abort_act;
    logic             busy_end;
    logic             cout_done;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [W-1:0]     op_m;
    logic [W-1:0]     res_done;
    logic [W-1:0]     res_end;
    logic [W-1:0]     opnd_end;
    logic [CNT_W-1:0] cnt_done;
    logic [CNT_W-1:0] cnt_end;
    logic [2*W+CNT_W+6:0] rst_vals;
  } obs_t;

  alu_op_sequencer_if #(.WIDTH(W)) din_if();

  alu_op_sequencer #(.WIDTH(W), .EXEC_CYCLES(EXEC), .CNT_WIDTH(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .din_if   (din_if),
    .opnd     (opnd),
    .ld_a     (ld_a),
    .ld_b     (ld_b),
    .ld_m     (ld_m),
    .alu_res  (alu_res),
    .alu_cout (alu_cout),
    .result   (result),
    .cout     (cout),
    .busy     (busy),
    .done     (done),
    .op_count (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference ALU: {carry, result}. Mode 0 AND, 1 ADD, 2 SUB (borrow), 3 XOR.
  function automatic logic [W:0] alu_f(input logic [W-1:0] a, b, m);
    case (m[1:0])
      2'd0:    return {1'b0, a & b};
      2'd1:    return {1'b0, a} + {1'b0, b};
      2'd2:    return {1'b0, a} - {1'b0, b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  // Operand register bank and ALU core sitting behind the sequencer.
  always @(posedge clk) begin
    if (ld_a) a_reg <= opnd;
    if (ld_b) b_reg <= opnd;
    if (ld_m) m_reg <= opnd;
  end
  assign {alu_cout, alu_res} = alu_f(a_reg, b_reg, m_reg);

  // Host driver/monitor for one operation; start is sampled at "edge 0",
  // cycle n is observed on the falling edge after rising edge n-1.
  task automatic do_op(input logic [W-1:0] a, b, m, input int stall_b, input bit abort_on_ld_b,
                       input bit poke_start, input int reset_at, input int window, output obs_t o);
    int stalled;
    bit abort_prev;
    o = '0;
    o.done_cyc = -1;
    stalled = 0;
    abort_prev = 1'b0;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; din_if.din = a; din_if.din_valid = 1'b1;
    for (int cyc = 1; cyc <= window; cyc++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      if (cyc == reset_at + 1) rst_n = 1'b1;
      if (abort_prev) o.post_abort_act = busy | din_if.din_ready | ld_a | ld_b | ld_m | done;
      abort_prev = 1'b0;
      if (int'(ld_a) + int'(ld_b) + int'(ld_m) > 1) o.overlap = 1'b1;
      if (ld_a) begin o.n_la++; o.op_a = opnd; din_if.din = b; end
      if (ld_b) begin
        o.n_lb++; o.op_b = opnd; din_if.din = m;
        if (abort_on_ld_b) begin abort = 1'b1; abort_prev = 1'b1; end
      end
      if (ld_m) begin o.n_lm++; o.op_m = opnd; din_if.din = W'($urandom); end
      if (done) begin
        o.n_done++; o.done_cyc = cyc;
        o.res_done = result; o.cout_done = cout; o.cnt_done = op_count;
      end
      din_if.din_valid = 1'b1;
      if (din_if.din_ready && o.n_la == 1 && o.n_lb == 0 && stalled < stall_b) begin
        din_if.din_valid = 1'b0;
        stalled++;
      end
      if (poke_start && o.n_lm == 1 && o.n_done == 0) start = 1'b1;
      o.busy_end = busy; o.res_end = result; o.cnt_end = op_count; o.opnd_end = opnd;
      if (cyc == reset_at) begin
        #2 rst_n = 1'b0;
        #1 o.rst_vals = {opnd, result, cout, op_count, ld_a, ld_b, ld_m, din_if.din_ready, busy, done};
      end
    end
    start = 1'b0; abort = 1'b0; din_if.din_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; din_if.din = '0; din_if.din_valid = 1'b0;
    #3;
    n_checks++;
    if ({opnd, result, cout, op_count} !== '0)
      $display("FAIL reset_data: got %0h required 0", {opnd, result, cout, op_count});
    else n_pass++;
    n_checks++;
    if ({ld_a, ld_b, ld_m, din_if.din_ready, busy, done} !== 6'b0)
      $display("FAIL reset_ctrl: got %b required 000000", {ld_a, ld_b, ld_m, din_if.din_ready, busy, done});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_nominal();
    obs_t o;
    logic [W:0] e;
    e = alu_f(4'd3, 4'd5, 4'd1);
    do_op(4'd3, 4'd5, 4'd1, 0, 1'b0, 1'b0, 0, BASE_LAT + 3, o);
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W); last_exp = e;
    n_checks++;
    if (o.done_cyc !== BASE_LAT) $display("FAIL nominal_latency: got %0d required %0d", o.done_cyc, BASE_LAT);
    else n_pass++;
    n_checks++;
    if ({o.n_la, o.n_lb, o.n_lm, o.n_done, 31'(o.overlap)} !== {32'd1, 32'd1, 32'd1, 32'd1, 31'd0})
      $display("FAIL nominal_pulses: la=%0d lb=%0d lm=%0d done=%0d overlap=%b required 1 1 1 1 0",
               o.n_la, o.n_lb, o.n_lm, o.n_done, o.overlap);
    else n_pass++;
    n_checks++;
    if ({o.op_a, o.op_b, o.op_m} !== {4'd3, 4'd5, 4'd1})
      $display("FAIL nominal_opnd: got %h required 351", {o.op_a, o.op_b, o.op_m});
    else n_pass++;
    n_checks++;
    if ({o.cout_done, o.res_done} !== e) $display("FAIL nominal_result: got %h required %h", {o.cout_done, o.res_done}, e);
    else n_pass++;
    n_checks++;
    if (int'(o.cnt_done) !== exp_cnt) $display("FAIL nominal_count: got %0d required %0d", o.cnt_done, exp_cnt);
    else n_pass++;
    n_checks++;
    if ({o.busy_end, o.opnd_end} !== {1'b0, 4'd1})
      $display("FAIL nominal_idle_hold: busy/opnd got %b/%h required 0/1", o.busy_end, o.opnd_end);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    obs_t o;
    logic [W-1:0] a, b, m;
    a = W'($urandom); b = W'($urandom); m = W'($urandom);
    do_op(a, b, m, 4, 1'b0, 1'b0, 0, BASE_LAT + 8, o);
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W); last_exp = alu_f(a, b, m);
    n_checks++;
    if (o.done_cyc !== BASE_LAT + 4) $display("FAIL stall_latency: got %0d required %0d", o.done_cyc, BASE_LAT + 4);
    else n_pass++;
    n_checks++;
    if ({o.n_lb, o.n_done, o.op_b} !== {32'd1, 32'd1, b})
      $display("FAIL stall_ldb: lb=%0d done=%0d opnd_b=%h required 1 1 %h", o.n_lb, o.n_done, o.op_b, b);
    else n_pass++;
    n_checks++;
    if ({o.cout_done, o.res_done} !== last_exp)
      $display("FAIL stall_result: got %h required %h", {o.cout_done, o.res_done}, last_exp);
    else n_pass++;
  endtask

  task automatic test_abort();
    obs_t o;
    logic [W-1:0] a, b, m;
    a = W'($urandom); b = W'($urandom); m = W'($urandom);
    do_op(a, b, m, 0, 1'b1, 1'b0, 0, 16, o);
    n_checks++;
    if ({o.n_la, o.n_lb, o.n_lm, o.n_done} !== {32'd1, 32'd1, 32'd0, 32'd0})
      $display("FAIL abort_pulses: la=%0d lb=%0d lm=%0d done=%0d required 1 1 0 0", o.n_la, o.n_lb, o.n_lm, o.n_done);
    else n_pass++;
    n_checks++;
    if ({o.post_abort_act, o.busy_end} !== 2'b00)
      $display("FAIL abort_idle: activity/busy got %b%b required 00", o.post_abort_act, o.busy_end);
    else n_pass++;
    n_checks++;
    if ({o.cout_done, o.res_end, o.cnt_end} !== {last_exp[W], last_exp[W-1:0], CNT_W'(exp_cnt)})
      $display("FAIL abort_hold: result/count got %h/%0d required %h/%0d", o.res_end, o.cnt_end, last_exp, exp_cnt);
    else n_pass++;
    a = W'($urandom); b = W'($urandom); m = W'($urandom);
    do_op(a, b, m, 0, 1'b0, 1'b0, 0, BASE_LAT + 3, o);
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W); last_exp = alu_f(a, b, m);
    n_checks++;
    if ({o.done_cyc, o.cout_done, o.res_done, o.cnt_done} !== {BASE_LAT, last_exp, CNT_W'(exp_cnt)})
      $display("FAIL abort_recover: cyc/res/cnt got %0d/%h/%0d required %0d/%h/%0d",
               o.done_cyc, {o.cout_done, o.res_done}, o.cnt_done, BASE_LAT, last_exp, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_start_busy();
    obs_t o;
    logic [W-1:0] a, b, m;
    a = W'($urandom); b = W'($urandom); m = W'($urandom);
    do_op(a, b, m, 0, 1'b0, 1'b1, 0, BASE_LAT + 4, o);
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W); last_exp = alu_f(a, b, m);
    n_checks++;
    if ({o.n_done, o.done_cyc, 31'(o.busy_end)} !== {32'd1, BASE_LAT, 31'd0})
      $display("FAIL start_ignored: dones=%0d cyc=%0d busy_end=%b required 1 %0d 0", o.n_done, o.done_cyc, o.busy_end, BASE_LAT);
    else n_pass++;
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_checks++;
    if ({busy, din_if.din_ready} !== 2'b00) $display("FAIL collision_idle: busy/ready got %b%b required 00", busy, din_if.din_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy, op_count} !== {1'b0, CNT_W'(exp_cnt)})
      $display("FAIL collision_hold: busy/count got %b/%0d required 0/%0d", busy, op_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    obs_t o;
    logic [W-1:0] a, b, m;
    int stall;
    for (int i = 0; i < 6; i++) begin
      a = W'($urandom); b = W'($urandom); m = W'($urandom);
      stall = int'($urandom_range(0, 3));
      do_op(a, b, m, stall, 1'b0, 1'b0, 0, BASE_LAT + stall + 3, o);
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W); last_exp = alu_f(a, b, m);
      n_checks++;
      if ({o.done_cyc, o.n_done, 32'(o.overlap)} !== {BASE_LAT + stall, 32'd1, 32'd0})
        $display("FAIL rand%0d_timing: cyc=%0d dones=%0d overlap=%b required %0d 1 0", i, o.done_cyc, o.n_done, o.overlap, BASE_LAT + stall);
      else n_pass++;
      n_checks++;
      if ({o.op_a, o.op_b, o.op_m, o.cout_done, o.res_done, o.cnt_done} !== {a, b, m, last_exp, CNT_W'(exp_cnt)})
        $display("FAIL rand%0d_data: opnds=%h res=%h cnt=%0d required %h %h %0d",
                 i, {o.op_a, o.op_b, o.op_m}, {o.cout_done, o.res_done}, o.cnt_done, {a, b, m}, last_exp, exp_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    obs_t o;
    logic [W-1:0] a, b, m;
    a = W'($urandom); b = W'($urandom); m = W'($urandom);
    // Cycle 7 is the first EXEC cycle; reset drops between clock edges there.
    do_op(a, b, m, 0, 1'b0, 1'b0, 7, BASE_LAT + 3, o);
    exp_cnt = 0; last_exp = '0;
    n_checks++;
    if (o.rst_vals !== '0) $display("FAIL async_reset_outputs: got %h required 0", o.rst_vals);
    else n_pass++;
    n_checks++;
    if ({o.n_lm, o.n_done, 31'(o.busy_end)} !== {32'd1, 32'd0, 31'd0})
      $display("FAIL async_reset_nodone: lm=%0d dones=%0d busy=%b required 1 0 0", o.n_lm, o.n_done, o.busy_end);
    else n_pass++;
    a = W'($urandom); b = W'($urandom); m = W'($urandom);
    do_op(a, b, m, 0, 1'b0, 1'b0, 0, BASE_LAT + 3, o);
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W); last_exp = alu_f(a, b, m);
    n_checks++;
    if ({o.done_cyc, o.cout_done, o.res_done, o.cnt_done} !== {BASE_LAT, last_exp, CNT_W'(exp_cnt)})
      $display("FAIL async_reset_rerun: cyc/res/cnt got %0d/%h/%0d required %0d/%h/%0d",
               o.done_cyc, {o.cout_done, o.res_done}, o.cnt_done, BASE_LAT, last_exp, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_counter_wrap();
    obs_t o;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      do_op(W'($urandom), W'($urandom), W'($urandom), 0, 1'b0, 1'b0, 0, BASE_LAT + 2, o);
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      n_checks++;
      if (int'(o.cnt_done) !== exp_cnt) $display("FAIL wrap_count%0d: got %0d required %0d", i, o.cnt_done, exp_cnt);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_abort();
    test_start_busy();
    test_random();
    test_async_reset();
    test_counter_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
